// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its busy scoreboard.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // Architectural zero register: reads as 0, never written, never busy.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pipeline hazard detection.
// A bit is set when an instruction targeting that register issues, and cleared
// when its result is written back. When both happen in the same cycle, the set
// wins because the newly issued producer supersedes the completing one.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_WR = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  issue_valid,
    input  logic [$clog2(NREGS)-1:0]              issue_addr,
    input  logic [NUM_WR-1:0]                     reg_wr,
    input  logic [NUM_WR-1:0][$clog2(NREGS)-1:0]  waddr,
    output logic [NREGS-1:0]                      busy_vec
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;

    // Next scoreboard state: writeback clears first, then issue sets on top of it.
    always_comb begin
        busy_next = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (reg_wr[j] && (waddr[j] == AW'(r))) begin
                    busy_next[r] = 1'b0;
                end
            end
            if (issue_valid && (issue_addr == AW'(r))) begin
                busy_next[r] = 1'b1;
            end
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    // Scoreboard register with synchronous active-low reset taking priority.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with a busy scoreboard.
// Reads are combinational; writes land on the rising clock edge, higher write
// port wins on an address collision, and register 0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_RD-1:0][$clog2(NREGS)-1:0]  raddr,
    output logic [NUM_RD-1:0][XLEN-1:0]           rdata,
    output logic [NUM_RD-1:0]                     rbusy,
    input  logic [NUM_WR-1:0]                     reg_wr,
    input  logic [NUM_WR-1:0][$clog2(NREGS)-1:0]  waddr,
    input  logic [NUM_WR-1:0][XLEN-1:0]           wdata,
    input  logic                                  issue_valid,
    input  logic [$clog2(NREGS)-1:0]              issue_addr,
    output logic [NREGS-1:0]                      busy_vec
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs [NREGS];

    // Storage update: ports are applied in ascending order so the highest
    // port index overrides a lower one targeting the same register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (reg_wr[j] && (waddr[j] != ZERO_ADDR)) begin
                    regs[waddr[j]] <= wdata[j];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .reg_wr      (reg_wr),
        .waddr       (waddr),
        .busy_vec    (busy_vec)
    );

    // Read muxing of stored data and busy bits, with optional write forwarding.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (raddr[i] != ZERO_ADDR) begin
                rdata[i] = regs[raddr[i]];
            end
            rbusy[i] = busy_vec[raddr[i]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (reg_wr[j] && (waddr[j] == raddr[i]) && (raddr[i] != ZERO_ADDR)) begin
                    rdata[i] = wdata[j];
                    if (!(issue_valid && (issue_addr == raddr[i]))) begin
                        rbusy[i] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a directed vector table, a short
// hand-written writeback sequence, and randomized cycles against a model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;
    localparam int NV     = 14;
    localparam int NH     = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                             clock = 1'b0;
    logic                             reset;
    logic [NUM_RD-1:0][AW-1:0]        raddr;
    logic [NUM_RD-1:0][XLEN-1:0]      rdata;
    logic [NUM_RD-1:0]                rbusy;
    logic [NUM_WR-1:0]                reg_wr;
    logic [NUM_WR-1:0][AW-1:0]        waddr;
    logic [NUM_WR-1:0][XLEN-1:0]      wdata;
    logic                             issue_valid;
    logic [AW-1:0]                    issue_addr;
    logic [NREGS-1:0]                 busy_vec;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural register contents and busy flags.
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;

    typedef struct {
        logic        rst_n;
        logic [1:0]  wr;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_bv;
    } vec_t;

    vec_t  tbl [NV];
    string tbl_name [NV];
    vec_t  hs [NH];

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .reg_wr      (reg_wr),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_vec    (busy_vec)
    );

    always #5 clock = ~clock;

    function automatic vec_t mkVec(
        input logic rst_n, input logic [1:0] wr,
        input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] e_rd0, input logic [31:0] e_rd1,
        input logic [1:0] e_rb, input logic [31:0] e_bv);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.wa0 = wa0; v.wd0 = wd0;
        v.wa1 = wa1; v.wd1 = wd1; v.iv = iv; v.ia = ia;
        v.ra0 = ra0; v.ra1 = ra1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        v.e_rb = e_rb; v.e_bv = e_bv;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst_n;
        reg_wr      = v.wr;
        waddr[0]    = v.wa0;
        wdata[0]    = v.wd0;
        waddr[1]    = v.wa1;
        wdata[1]    = v.wd1;
        issue_valid = v.iv;
        issue_addr  = v.ia;
        raddr[0]    = v.ra0;
        raddr[1]    = v.ra1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                               input logic [1:0] e_rb, input logic [31:0] e_bv);
        cmp({name, ".rdata0"}, rdata[0], e_rd0);
        cmp({name, ".rdata1"}, rdata[1], e_rd1);
        cmp({name, ".rbusy0"}, {31'b0, rbusy[0]}, {31'b0, e_rb[0]});
        cmp({name, ".rbusy1"}, {31'b0, rbusy[1]}, {31'b0, e_rb[1]});
        cmp({name, ".busy_vec"}, busy_vec, e_bv);
    endtask

    // Apply the architectural effect of the current inputs at a rising edge.
    task automatic modelUpdate();
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
            m_busy = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (reg_wr[j] && waddr[j] != 0) begin
                    m_regs[waddr[j]] = wdata[j];
                    m_busy[waddr[j]] = 1'b0;
                end
            end
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] expData(input int i);
        logic [31:0] v;
        int a;
        a = int'(raddr[i]);
        v = (a == 0) ? 32'h0 : m_regs[a];
        if (BYP) begin
            for (int j = 0; j < NUM_WR; j++)
                if (reg_wr[j] && int'(waddr[j]) == a && a != 0) v = wdata[j];
        end
        return v;
    endfunction

    function automatic logic expBusy(input int i);
        logic b;
        int a;
        a = int'(raddr[i]);
        b = m_busy[a];
        if (BYP) begin
            for (int j = 0; j < NUM_WR; j++)
                if (reg_wr[j] && int'(waddr[j]) == a && a != 0 &&
                    !(issue_valid && int'(issue_addr) == a)) b = 1'b0;
        end
        return b;
    endfunction

    // One clock cycle: drive, optionally compare before the edge, then advance.
    task automatic runVec(input vec_t v, input string name, input bit do_check);
        applyStimulus(v);
        #3;
        if (do_check) checkOutput(name, v.e_rd0, v.e_rd1, v.e_rb, v.e_bv);
        @(posedge clock);
        modelUpdate();
        #1;
    endtask

    task automatic randomCycle(input int n);
        vec_t v;
        v.rst_n = ($urandom_range(0, 31) != 0);
        v.wr    = 2'($urandom_range(0, 3));
        v.wa0   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        v.wa1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        v.wd0   = $urandom;
        v.wd1   = $urandom;
        v.iv    = $urandom_range(0, 1) == 1;
        v.ia    = 5'($urandom_range(0, 7));
        v.ra0   = 5'($urandom_range(0, 7));
        v.ra1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        applyStimulus(v);
        #3;
        checkOutput($sformatf("rand%0d", n), expData(0), expData(1),
                    {expBusy(1), expBusy(0)}, m_busy);
        @(posedge clock);
        modelUpdate();
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Directed table: each row is one cycle; expectations are the reads before its edge.
        tbl_name[0]  = "reset_read";
        tbl[0]  = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 31, 0, 0, 2'b00, 0);
        tbl_name[1]  = "wr_x7";
        tbl[1]  = mkVec(1, 2'b01, 7, 32'hDEADBEEF, 0, 0, 0, 0, 5, 31, 0, 0, 2'b00, 0);
        tbl_name[2]  = "wr_x0";
        tbl[2]  = mkVec(1, 2'b01, 0, 32'h12345678, 0, 0, 0, 0, 7, 0, 32'hDEADBEEF, 0, 2'b00, 0);
        tbl_name[3]  = "rd_x7_x0";
        tbl[3]  = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 32'hDEADBEEF, 0, 2'b00, 0);
        tbl_name[4]  = "collide_x3";
        tbl[4]  = mkVec(1, 2'b11, 3, 32'h11, 3, 32'h22, 0, 0, 7, 1, 32'hDEADBEEF, 0, 2'b00, 0);
        tbl_name[5]  = "rd_x3";
        tbl[5]  = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 32'h22, 32'hDEADBEEF, 2'b00, 0);
        tbl_name[6]  = "issue_x9";
        tbl[6]  = mkVec(1, 2'b00, 0, 0, 0, 0, 1, 9, 9, 3, 0, 32'h22, 2'b00, 0);
        tbl_name[7]  = "issue_wr_x9";
        tbl[7]  = mkVec(1, 2'b01, 9, 32'h99, 0, 0, 1, 9, 9, 9,
                        BYP ? 32'h99 : 32'h0, BYP ? 32'h99 : 32'h0, 2'b11, 32'h200);
        tbl_name[8]  = "wr_x9";
        tbl[8]  = mkVec(1, 2'b01, 9, 32'h77, 0, 0, 0, 0, 9, 0,
                        BYP ? 32'h77 : 32'h99, 0, BYP ? 2'b00 : 2'b01, 32'h200);
        tbl_name[9]  = "issue_x0";
        tbl[9]  = mkVec(1, 2'b00, 0, 0, 0, 0, 1, 0, 9, 0, 32'h77, 0, 2'b00, 0);
        tbl_name[10] = "bypass_x4";
        tbl[10] = mkVec(1, 2'b01, 4, 32'hA5A5A5A5, 0, 0, 0, 0, 4, 0,
                        BYP ? 32'hA5A5A5A5 : 32'h0, 0, 2'b00, 0);
        tbl_name[11] = "rd_x4_issue_x12";
        tbl[11] = mkVec(1, 2'b00, 0, 0, 0, 0, 1, 12, 4, 9, 32'hA5A5A5A5, 32'h77, 2'b00, 0);
        tbl_name[12] = "mid_reset";
        tbl[12] = mkVec(0, 2'b01, 10, 32'h55, 0, 0, 1, 10, 4, 12, 32'hA5A5A5A5, 0, 2'b10, 32'h1000);
        tbl_name[13] = "after_reset";
        tbl[13] = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 10, 4, 0, 0, 2'b00, 0);

        // Hand-written sequence: dual-port writeback, busy lifetime, port-1 writeback.
        hs[0] = mkVec(1, 2'b11, 21, 32'h2121, 20, 32'h2020, 1, 20, 20, 21,
                      BYP ? 32'h2020 : 32'h0, BYP ? 32'h2121 : 32'h0, 2'b00, 0);
        hs[1] = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 20, 21, 32'h2020, 32'h2121, 2'b01, 32'h0010_0000);
        hs[2] = mkVec(1, 2'b10, 0, 0, 20, 32'hBEEF, 0, 0, 20, 0,
                      BYP ? 32'hBEEF : 32'h2020, 0, BYP ? 2'b00 : 2'b01, 32'h0010_0000);
        hs[3] = mkVec(1, 2'b00, 0, 0, 0, 0, 0, 0, 20, 21, 32'hBEEF, 32'h2121, 2'b00, 0);

        // Hold reset low for two cycles with harmless inputs.
        runVec(mkVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "reset", 1'b0);
        runVec(mkVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "reset", 1'b0);

        for (int k = 0; k < NV; k++) runVec(tbl[k], tbl_name[k], 1'b1);
        for (int k = 0; k < NH; k++) runVec(hs[k], $sformatf("seq%0d", k), 1'b1);

        for (int n = 0; n < 400; n++) randomCycle(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined successor of the single-cycle core.
- Generalises register count, data width, read-port count and write-port count.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) for hazard detection by the pipeline control unit.
- Register 0 is hardwired to zero in both the storage and the scoreboard.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 1, number of write ports; range 1..2.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- raddr  input  NUM_RD x $clog2(NREGS)  read addresses.
- rdata  output  NUM_RD x XLEN  read data.
- rbusy  output  NUM_RD  busy bit of the register addressed by each read port.
- reg_wr  input  NUM_WR  write enables.
- waddr  input  NUM_WR x $clog2(NREGS)  write addresses.
- wdata  input  NUM_WR x XLEN  write data.
- issue_valid  input  1  marks issue_addr as having a pending producer.
- issue_addr  input  $clog2(NREGS)  destination register of the issued instruction.
- busy_vec  output  NREGS  full scoreboard, for debug and stall logic.

Behaviour:
- Reset: sampled at the rising clock edge while reset==0. Clears all registers to 0 and all busy bits to 0.
  - reset has priority over every write and issue in that cycle.
  - Reset asserted mid-operation discards in-flight writes and issues of that cycle.
- Outputs after reset: rdata = 0 on every port, rbusy = 0, busy_vec = 0.
- Reads: combinational, zero latency.
  - rdata[i] = reg[raddr[i]].
  - raddr[i]==0 always returns 0.
- Writes: take effect at the rising edge when reg_wr[j]==1 and waddr[j]!=0.
  - Writes to address 0 are ignored and never change reg[0].
  - Written data is visible on rdata starting the cycle after the edge (no bypass unless the optional feature is enabled).
- Write-port collision: two ports writing the same nonzero address in one cycle → the higher port index wins.
- Scoreboard, per register r != 0, evaluated at each rising edge:
  - Set when issue_valid==1 and issue_addr==r.
  - Cleared when any reg_wr[j]==1 with waddr[j]==r.
  - Set and clear on the same r in the same cycle → set wins, because the new producer supersedes the completing one.
  - issue_addr==0 is ignored; busy[0] is constant 0.
- rbusy[i] = busy[raddr[i]], combinational. rbusy reflects the registered scoreboard only and is not adjusted for same-cycle writeback.
- Out-of-range addresses cannot occur because NREGS is a power of two.
- No X propagation: storage is fully initialised by reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rdata[i] forwards wdata[j] combinationally when reg_wr[j]==1 and waddr[j]==raddr[i]!=0; the highest j wins.
  - rbusy[i] is forced to 0 in the same condition, unless issue_valid re-targets that register in the same cycle.
- Undefined: no forwarding; the read returns the old value until the next cycle.
- Storage and scoreboard update are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - Default XLEN and NREGS constants.
  - Typedefs reg_addr_t (logic [$clog2(NREGS)-1:0]) and xlen_t.
  - Constant ZERO_REG = 0.
- Sub-module regfile_scoreboard: NREGS busy bits with issue-set / writeback-clear and the set-wins priority. Instantiated once; exposes busy_vec.
- Storage, write arbitration and read/bypass muxing stay in regfile_mp.

Test Plan:
- Reset then read: hold reset=0 for 2 cycles, release; read x5 and x31 on ports 0/1 → rdata=0, rbusy=0, busy_vec=0.
- Write/read and x0 protection: write x7=0xDEADBEEF, then write x0=0x12345678; next cycle read x7, x0 → 0xDEADBEEF, 0x00000000.
- Port collision (NUM_WR=2): port0 writes x3=0x11, port1 writes x3=0x22 in the same cycle → next cycle rdata(x3)=0x22.
- Scoreboard:
  - issue x9 → busy_vec[9]=1 next cycle.
  - In the same cycle, issue x9 and write x9 → busy stays 1.
  - Write x9 alone → busy_vec[9]=0.
  - issue x0 → busy_vec[0] stays 0.
- Bypass: write x4=0xA5A5A5A5 while reading x4 in the same cycle.
  - With REGFILE_BYPASS_EN: rdata=0xA5A5A5A5, rbusy=0 that cycle.
  - Without it: old value returned that cycle, 0xA5A5A5A5 the next.
- Reset mid-operation: write x10=0x55 and issue x10 in the same cycle as reset=0 → next cycle x10=0, busy_vec[10]=0.
